// File: rtl/if_fetch_unit_if.sv
// Fetch-unit bundle: pipeline control in, instruction memory req/ack, IF_ID outputs.
// master = fetch unit side, slave = pipeline/memory environment side.
interface if_fetch_unit_if;
  logic        freeze;
  logic        branchTaken;
  logic [31:0] branchAddress;
  logic        memReq;
  logic [31:0] memAddr;
  logic        memAck;
  logic [31:0] memRdata;
  logic [31:0] PCPlus;
  logic [31:0] inst;
  logic        instValid;

  modport master (
    input  freeze, branchTaken, branchAddress, memAck, memRdata,
    output memReq, memAddr, PCPlus, inst, instValid
  );

  modport slave (
    output freeze, branchTaken, branchAddress, memAck, memRdata,
    input  memReq, memAddr, PCPlus, inst, instValid
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches over a variable-latency req/ack
// handshake and presents PCPlus/inst/instValid to IF_ID, with branch redirect.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic            clk,
  input logic            rst,
  if_fetch_unit_if.master fu
);

  typedef enum logic [1:0] {S_FETCH, S_VALID, S_DISCARD} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] stale_addr_q, stale_addr_d;
  logic [31:0] pc_plus_q, pc_plus_d;
  logic [31:0] inst_q, inst_d;
  logic        inst_valid_q, inst_valid_d;

  logic        mem_req;
  logic [31:0] mem_addr;
  logic        ack;

  // Request is a pure function of state so an outstanding fetch never changes
  // address or drops while waiting; a branch only redirects pc for later.
  always_comb begin
    mem_req  = 1'b0;
    mem_addr = pc_q;
    if (!rst) begin
      case (state_q)
        S_FETCH:   mem_req = 1'b1;
        S_VALID:   mem_req = !fu.freeze;
        S_DISCARD: begin
          mem_req  = 1'b1;
          mem_addr = stale_addr_q;
        end
        default:   mem_req = 1'b0;
      endcase
    end
  end

  assign ack = fu.memAck & mem_req;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    stale_addr_d = stale_addr_q;
    pc_plus_d    = pc_plus_q;
    inst_d       = inst_q;
    inst_valid_d = inst_valid_q;

    if (fu.branchTaken) begin
      pc_d         = fu.branchAddress & 32'hFFFF_FFFC;
      inst_valid_d = 1'b0;
      // An unacked request must still be drained; its response is dropped.
      if (mem_req && !ack) begin
        state_d      = S_DISCARD;
        stale_addr_d = mem_addr;
      end else begin
        state_d = S_FETCH;
      end
    end else begin
      case (state_q)
        S_FETCH: begin
          if (ack) begin
            inst_d       = fu.memRdata;
            pc_plus_d    = pc_q + 32'd4;
            pc_d         = pc_q + 32'd4;
            inst_valid_d = 1'b1;
            state_d      = S_VALID;
          end
        end
        S_VALID: begin
          if (!fu.freeze) begin
            if (ack) begin
              inst_d       = fu.memRdata;
              pc_plus_d    = pc_q + 32'd4;
              pc_d         = pc_q + 32'd4;
              inst_valid_d = 1'b1;
            end else begin
              inst_valid_d = 1'b0;
              state_d      = S_FETCH;
            end
          end
        end
        S_DISCARD: begin
          if (ack) state_d = S_FETCH;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      stale_addr_q <= 32'h0;
      pc_plus_q    <= 32'h0;
      inst_q       <= 32'h0;
      inst_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      stale_addr_q <= stale_addr_d;
      pc_plus_q    <= pc_plus_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
    end
  end

  assign fu.memReq    = mem_req;
  assign fu.memAddr   = mem_addr;
  assign fu.PCPlus    = pc_plus_q;
  assign fu.inst      = inst_q;
  assign fu.instValid = inst_valid_q;

endmodule
